// File: rtl/vector_pkg.sv
// vector_pkg: shared types and constants for the vector draw engine
package vector_pkg;
  localparam int DEF_WIDTH = 12;
  localparam int MAX_W = 16;
  localparam logic [1:0] CH_X = 2'd0;
  localparam logic [1:0] CH_Y = 2'd1;
  localparam logic [1:0] CH_Z = 2'd2;
  typedef enum logic [2:0] {IDLE, LOAD, STEP, EMIT, WAIT} state_t;
  typedef struct packed {
    logic [MAX_W-1:0] x;
    logic [MAX_W-1:0] y;
    logic [MAX_W-1:0] z;
    logic             blank;
  } point_t;
endpackage

// File: rtl/point_fifo.sv
// point_fifo: synchronous FIFO
// ports: push/din write side, pop/dout read side (dout shows head), full/empty/count status
module point_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/vector_draw_engine.sv
// vector_draw_engine: buffers target points and walks the beam to each with Bresenham steps
// ports: x/y/z/blank + strobe/ready point input; dac_value/dac_axis/dac_strobe + dac_ready word output; busy
module vector_draw_engine import vector_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic             blank,
  input  logic             strobe,
  output logic             ready,
  output logic [WIDTH-1:0] dac_value,
  output logic [1:0]       dac_axis,
  output logic             dac_strobe,
  input  logic             dac_ready,
  output logic             busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state_q, state_d;
  point_t pin, pout;
  logic full, empty, push, pop, xfer, last_ch, at_target, step_x, step_y;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] cur_x_q, cur_y_q, cur_x_d, cur_y_d, tx_q, ty_q, zc_q, lx, ly;
  logic tb_q, sx_q, sy_q;
  logic [WIDTH:0] dx_q, dy_q, ldx, ldy, sub_v, add_v;
  logic signed [WIDTH+1:0] err_q, err_d;
  logic signed [WIDTH+2:0] e2;
  logic [1:0] ch_q;
  assign pin = '{x: MAX_W'(x), y: MAX_W'(y), z: MAX_W'(z), blank: blank};
  assign ready = !full;
  assign push = strobe && ready;
  assign pop = state_q == LOAD;
  point_fifo #(.DW($bits(point_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .din(pin), .pop(pop),
    .dout(pout), .full(full), .empty(empty), .count(count)
  );
  assign lx = WIDTH'(pout.x);
  assign ly = WIDTH'(pout.y);
  assign ldx = lx >= cur_x_q ? {1'b0, lx - cur_x_q} : {1'b0, cur_x_q - lx};
  assign ldy = ly >= cur_y_q ? {1'b0, ly - cur_y_q} : {1'b0, cur_y_q - ly};
  assign at_target = cur_x_q == tx_q && cur_y_q == ty_q;
  assign last_ch = ch_q == 2'(NUM_CH - 1);
  // sx/sy registers hold the sign; {sign..., 1} is +1 or -1 in two's complement
  always_comb begin
    e2 = $signed({err_q, 1'b0});
    step_x = e2 > -$signed({2'b0, dy_q});
    step_y = e2 < $signed({2'b0, dx_q});
    sub_v = step_x ? dy_q : '0;
    add_v = step_y ? dx_q : '0;
    err_d = err_q - $signed({1'b0, sub_v}) + $signed({1'b0, add_v});
    cur_x_d = tb_q ? tx_q : step_x ? cur_x_q + {{(WIDTH-1){sx_q}}, 1'b1} : cur_x_q;
    cur_y_d = tb_q ? ty_q : step_y ? cur_y_q + {{(WIDTH-1){sy_q}}, 1'b1} : cur_y_q;
  end
  always_ff @(posedge clk)
    state_q <= reset ? IDLE : state_d;
  // IDLE also reacts to a push in flight so LOAD follows the accept directly
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = (!empty || push) ? LOAD : IDLE;
      LOAD: state_d = STEP;
      STEP: state_d = EMIT;
      EMIT: state_d = !dac_ready ? EMIT : !last_ch ? WAIT : !at_target ? STEP : !empty ? LOAD : IDLE;
      WAIT: state_d = dac_ready ? EMIT : WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    xfer = state_q == EMIT && dac_ready;
    dac_strobe = xfer;
    dac_axis = ch_q;
    dac_value = ch_q == CH_X ? cur_x_q : ch_q == CH_Y ? cur_y_q : zc_q;
    busy = count != '0 || state_q != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_x_q <= '0;
      cur_y_q <= '0;
      tx_q <= '0;
      ty_q <= '0;
      zc_q <= '0;
      tb_q <= 1'b0;
      sx_q <= 1'b0;
      sy_q <= 1'b0;
      dx_q <= '0;
      dy_q <= '0;
      err_q <= '0;
      ch_q <= CH_X;
    end else begin
      if (state_q == LOAD) begin
        tx_q <= lx;
        ty_q <= ly;
        tb_q <= pout.blank;
        zc_q <= pout.blank ? '0 : WIDTH'(pout.z);
        dx_q <= ldx;
        dy_q <= ldy;
        sx_q <= lx < cur_x_q;
        sy_q <= ly < cur_y_q;
        err_q <= $signed({1'b0, ldx}) - $signed({1'b0, ldy});
      end
      if (state_q == STEP) begin
        cur_x_q <= cur_x_d;
        cur_y_q <= cur_y_d;
        err_q <= err_d;
        ch_q <= CH_X;
      end
      if (xfer) ch_q <= last_ch ? CH_X : ch_q + 2'd1;
    end
  end
endmodule

// File: tb/tb_vector_draw_engine.sv
// tb_vector_draw_engine: directed checks of a 2-channel and a 3-channel engine
module tb_vector_draw_engine;
  logic clk = 0, reset = 1, st2 = 0, st3 = 0, bi = 0, dr = 1;
  logic [11:0] xi = 0, yi = 0, zi = 0;
  logic r2, s2, b2, r3, s3, b3;
  logic [11:0] v2, v3;
  logic [1:0] a2, a3;
  int cyc = 0, n_cmp = 0, n_fail = 0;
  logic [13:0] q2[$], q3[$];
  int cq2[$];
  vector_draw_engine #(.WIDTH(12), .FIFO_DEPTH(4), .NUM_CH(2)) d2 (
    .clk(clk), .reset(reset), .x(xi), .y(yi), .z(zi), .blank(bi), .strobe(st2), .ready(r2),
    .dac_value(v2), .dac_axis(a2), .dac_strobe(s2), .dac_ready(dr), .busy(b2)
  );
  vector_draw_engine #(.WIDTH(12), .FIFO_DEPTH(4), .NUM_CH(3)) d3 (
    .clk(clk), .reset(reset), .x(xi), .y(yi), .z(zi), .blank(bi), .strobe(st3), .ready(r3),
    .dac_value(v3), .dac_axis(a3), .dac_strobe(s3), .dac_ready(dr), .busy(b3)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (s2) begin
      q2.push_back({a2, v2});
      cq2.push_back(cyc);
    end
    if (s3) q3.push_back({a3, v3});
  end
  task automatic do_reset;
    @(posedge clk);
    #1 reset = 1; st2 = 0; st3 = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    q2.delete(); q3.delete(); cq2.delete();
  endtask
  task automatic send(input int inst, input int px, input int py, input int pz, input logic pb, output int k);
    @(posedge clk);
    #1 xi = 12'(px); yi = 12'(py); zi = 12'(pz); bi = pb;
    st2 = inst == 2; st3 = inst == 3; k = cyc;
    @(posedge clk);
    #1 st2 = 0; st3 = 0;
  endtask
  task automatic wait_idle(input int inst, input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (!(inst == 2 ? b2 : b3)) begin
        c = cyc;
        break;
      end
    end
    n_cmp++;
    if (c < 0) begin
      n_fail++;
      $display("FAIL idle_timeout inst=%0d still busy after %0d cycles, want idle", inst, budget);
    end
  endtask
  task automatic test_reset;
    do_reset();
    @(negedge clk);
    n_cmp++; if (r2 !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", r2); end
    n_cmp++; if (b2 !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", b2); end
    n_cmp++; if (s2 !== 1'b0) begin n_fail++; $display("FAIL rst_strobe got %b want 0", s2); end
    n_cmp++; if (a2 !== 2'd0) begin n_fail++; $display("FAIL rst_axis got %0d want 0", a2); end
    n_cmp++; if (v2 !== 12'd0) begin n_fail++; $display("FAIL rst_value got %0d want 0", v2); end
    n_cmp++; if (r3 !== 1'b1 || b3 !== 1'b0) begin n_fail++; $display("FAIL rst_d3 got ready=%b busy=%b want 1 0", r3, b3); end
  endtask
  task automatic test_line;
    int k, c;
    int ea[6] = '{0, 1, 0, 1, 0, 1};
    int ev[6] = '{1, 0, 2, 1, 3, 1};
    dr = 1;
    send(2, 3, 1, 0, 0, k);
    wait_idle(2, 100, c);
    n_cmp++; if (q2.size() != 6) begin n_fail++; $display("FAIL line_count got %0d want 6", q2.size()); end
    for (int i = 0; i < 6 && i < q2.size(); i++) begin
      n_cmp++;
      if (q2[i] !== {2'(ea[i]), 12'(ev[i])}) begin
        n_fail++; $display("FAIL line_word%0d got axis %0d val %0d want axis %0d val %0d", i, q2[i][13:12], q2[i][11:0], ea[i], ev[i]);
      end
    end
    n_cmp++; if (cq2.size() < 2 || cq2[0] != k + 3) begin n_fail++; $display("FAIL line_first_strobe got cycle %0d want %0d", cq2.size() ? cq2[0] : -1, k + 3); end
    n_cmp++; if (cq2.size() < 2 || cq2[1] != k + 5) begin n_fail++; $display("FAIL line_second_strobe got cycle %0d want %0d", cq2.size() > 1 ? cq2[1] : -1, k + 5); end
    n_cmp++; if (cq2.size() == 0 || c != cq2[cq2.size()-1] + 1) begin n_fail++; $display("FAIL line_busy_fall got cycle %0d want last strobe + 1", c); end
  endtask
  task automatic test_zero_len;
    int k, c;
    q2.delete(); cq2.delete();
    send(2, 3, 1, 0, 0, k);
    wait_idle(2, 100, c);
    n_cmp++; if (q2.size() != 2) begin n_fail++; $display("FAIL zero_count got %0d want 2", q2.size()); end
    n_cmp++; if (q2.size() != 2 || q2[0] !== {2'd0, 12'd3} || q2[1] !== {2'd1, 12'd1}) begin n_fail++; $display("FAIL zero_point got %h %h want 0003 1001", q2.size() > 0 ? q2[0] : 14'h0, q2.size() > 1 ? q2[1] : 14'h0); end
  endtask
  task automatic test_blank;
    int k, c;
    send(3, 3, 1, 55, 0, k);
    wait_idle(3, 100, c);
    n_cmp++; if (q3.size() != 9) begin n_fail++; $display("FAIL z_count got %0d want 9", q3.size()); end
    n_cmp++; if (q3.size() != 9 || q3[8] !== {2'd2, 12'd55} || q3[6] !== {2'd0, 12'd3}) begin n_fail++; $display("FAIL z_word got last %h want 2037", q3.size() ? q3[q3.size()-1] : 14'h0); end
    q3.delete();
    send(3, 100, 200, 77, 1, k);
    wait_idle(3, 100, c);
    n_cmp++; if (q3.size() != 3) begin n_fail++; $display("FAIL blank_count got %0d want 3", q3.size()); end
    n_cmp++; if (q3.size() != 3 || q3[0] !== {2'd0, 12'd100} || q3[1] !== {2'd1, 12'd200} || q3[2] !== {2'd2, 12'd0}) begin n_fail++; $display("FAIL blank_point got %0d words want (100,200,0)", q3.size()); end
  endtask
  task automatic test_back_to_back;
    int k, c;
    do_reset();
    dr = 0;
    send(2, 1, 1, 0, 0, k);
    repeat (4) @(posedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1 xi = 12'(i + 1); yi = 12'(i + 1); bi = 0; st2 = 1;
      @(negedge clk);
      n_cmp++; if (r2 !== (i < 5)) begin n_fail++; $display("FAIL b2b_ready%0d got %b want %b", i, r2, i < 5); end
    end
    @(posedge clk);
    #1 st2 = 0;
    @(negedge clk);
    n_cmp++; if (r2 !== 1'b0 || q2.size() != 0) begin n_fail++; $display("FAIL b2b_stalled got ready=%b words=%0d want 0 0", r2, q2.size()); end
    dr = 1;
    wait_idle(2, 500, c);
    n_cmp++; if (q2.size() != 10) begin n_fail++; $display("FAIL b2b_count got %0d want 10", q2.size()); end
    for (int i = 0; i < 5 && 2 * i + 1 < q2.size(); i++) begin
      n_cmp++;
      if (q2[2*i] !== {2'd0, 12'(i + 1)} || q2[2*i+1] !== {2'd1, 12'(i + 1)}) begin
        n_fail++; $display("FAIL b2b_point%0d got %h %h want (%0d,%0d)", i, q2[2*i], q2[2*i+1], i + 1, i + 1);
      end
    end
  endtask
  task automatic test_long;
    int k, c, bad;
    do_reset();
    dr = 1;
    send(2, 4095, 4095, 0, 0, k);
    wait_idle(2, 20000, c);
    n_cmp++; if (q2.size() != 8190) begin n_fail++; $display("FAIL diag_count got %0d want 8190", q2.size()); end
    bad = 0;
    for (int i = 0; i < 4095 && 2 * i + 1 < q2.size(); i++)
      if (q2[2*i] !== {2'd0, 12'(i + 1)} || q2[2*i+1] !== {2'd1, 12'(i + 1)}) bad++;
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL diag_path got %0d bad points want 0", bad); end
    n_cmp++; if (q2.size() == 0 || q2[q2.size()-1] !== {2'd1, 12'd4095}) begin n_fail++; $display("FAIL diag_end got %h want 1fff", q2.size() ? q2[q2.size()-1] : 14'h0); end
    send(2, 4095, 0, 0, 1, k);
    wait_idle(2, 100, c);
    q2.delete(); cq2.delete();
    send(2, 0, 4095, 0, 0, k);
    wait_idle(2, 20000, c);
    n_cmp++; if (q2.size() != 8190) begin n_fail++; $display("FAIL anti_count got %0d want 8190", q2.size()); end
    bad = 0;
    for (int i = 0; i < 4095 && 2 * i + 1 < q2.size(); i++)
      if (q2[2*i] !== {2'd0, 12'(4094 - i)} || q2[2*i+1] !== {2'd1, 12'(i + 1)}) bad++;
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL anti_path got %0d bad points want 0", bad); end
    n_cmp++; if (q2.size() < 2 || q2[q2.size()-2] !== {2'd0, 12'd0}) begin n_fail++; $display("FAIL anti_end got %h want 0000", q2.size() > 1 ? q2[q2.size()-2] : 14'h0); end
  endtask
  task automatic test_reset_mid;
    int k, c;
    bit hit;
    do_reset();
    dr = 1;
    send(2, 10, 0, 0, 0, k);
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (q2.size() >= 3) begin
        hit = 1;
        break;
      end
    end
    n_cmp++; if (!hit) begin n_fail++; $display("FAIL mid_wait got %0d words want 3", q2.size()); end
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    n_cmp++; if (s2 !== 1'b0) begin n_fail++; $display("FAIL mid_strobe got %b want 0", s2); end
    n_cmp++; if (b2 !== 1'b0 || r2 !== 1'b1) begin n_fail++; $display("FAIL mid_status got busy=%b ready=%b want 0 1", b2, r2); end
    q2.delete(); cq2.delete();
    send(2, 2, 0, 0, 0, k);
    wait_idle(2, 100, c);
    n_cmp++; if (q2.size() != 4 || q2[0] !== {2'd0, 12'd1} || q2[1] !== {2'd1, 12'd0} || q2[2] !== {2'd0, 12'd2}) begin n_fail++; $display("FAIL mid_restart got %0d words first %h want 4 words from (1,0)", q2.size(), q2.size() ? q2[0] : 14'h0); end
  endtask
  initial begin
    test_reset();
    test_line();
    test_zero_len();
    test_blank();
    test_back_to_back();
    test_long();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
